// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and magnitude helper for alu_muldiv
package muldiv_pkg;
  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  // Two's-complement negation modulo 2^64; callers keep the low WIDTH bits, so the
  // most-negative value maps to 2^(WIDTH-1).
  function automatic logic [63:0] abs_mag(input logic [63:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 multiply (shift-add) or restoring divide iteration
// Divide path present only with ALU_MULDIV_DIV_EN defined.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               mode,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {sum, acc[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0] t;
  logic [WIDTH-1:0] d;
  logic ge;
  assign t = acc[2*WIDTH-1:WIDTH-1];
  assign ge = t >= {1'b0, opnd};
  assign d = t[WIDTH-1:0] - opnd;
  assign nxt = mode ? {ge ? d : t[WIDTH-1:0], acc[WIDTH-2:0], ge} : mul_nxt;
`else
  assign nxt = mode ? acc : mul_nxt;
`endif
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers
// ALU_MULDIV_DIV_EN enables the divider; otherwise DIV/DIVU report err like reserved ops.
module alu_muldiv import muldiv_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0,
  output logic             err
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, nxt, prod;
  logic [WIDTH-1:0] opnd, ma, mb, quo, rem;
  logic dv, zf, quick, neg_q, neg_r, go, is_mul, is_div;
  assign go = start & (state == S_IDLE | state == S_DONE);
  assign is_mul = op == OP_MULTU | op == OP_MULT;
`ifdef ALU_MULDIV_DIV_EN
  assign is_div = op == OP_DIVU | op == OP_DIV;
`else
  assign is_div = 1'b0;
`endif
  assign ma = WIDTH'(abs_mag(64'(a), op[0] & a[WIDTH-1]));
  assign mb = WIDTH'(abs_mag(64'(b), op[0] & b[WIDTH-1]));
  assign prod = neg_q ? -acc : acc;
  assign quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  // quick marks the one-cycle MTHI/MTLO/reserved path, which is never reported as busy
  assign busy = state == S_CALC | (state == S_FIX & ~quick);
  assign done = state == S_DONE;
  muldiv_step #(.WIDTH(WIDTH)) u_step (.acc(acc), .opnd(opnd), .mode(dv), .nxt(nxt));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      {dv, zf, quick, neg_q, neg_r} <= '0;
      hi <= '0;
      lo <= '0;
      div0 <= 1'b0;
      err <= 1'b0;
    end else if (go) begin
      cnt <= '0;
      quick <= ~(is_mul | is_div);
      div0 <= is_div & ~|b;
      err <= ~(is_mul | is_div | op == OP_MTHI | op == OP_MTLO);
      state <= (is_mul | is_div) ? S_CALC : S_FIX;
      if (is_mul | is_div) begin
        dv <= is_div;
        zf <= is_div & ~|b;
        neg_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= op[0] & a[WIDTH-1];
        opnd <= is_div ? mb : ma;
        acc <= {{WIDTH{1'b0}}, is_div ? (~|b ? a : ma) : mb};
      end
      if (op == OP_MTHI) hi <= a;
      if (op == OP_MTLO) lo <= a;
    end else if (state == S_CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (!zf) acc <= nxt;
      if (zf || cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
    end else if (state == S_FIX) begin
      state <= S_DONE;
      if (!quick) begin
        hi <= zf ? acc[WIDTH-1:0] : dv ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= zf ? '1 : dv ? quo : prod[WIDTH-1:0];
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized scoreboard bench for alu_muldiv (WIDTH=32)
module tb_alu_muldiv;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div0, err;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0, cyc = 0, bcnt = 0;
  logic [31:0] mhi = '0, mlo = '0;
  typedef struct {
    logic [31:0] hi, lo;
    logic div0, err;
    int lat, bsy, t0;
  } exp_t;
  exp_t sb[$];

  alu_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=1 want=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div0", 64'(div0), 64'(e.div0));
          chk("err", 64'(err), 64'(e.err));
          chk("latency", 64'(cyc - e.t0), 64'(e.lat));
          chk("busy_cycles", 64'(bcnt), 64'(e.bsy));
          chk("busy_in_done", 64'(busy), 64'(0));
        end
        bcnt = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sa, sy;
    logic [63:0] p;
    int n = 0;
    @(negedge clk);
    while (sb.size() != 0 && !done) begin
      if (++n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout got=busy want=done within 200 cycles");
        break;
      end
      @(negedge clk);
    end
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    sa = longint'($signed(x));
    sy = longint'($signed(y));
    e.div0 = 1'b0; e.err = 1'b0; e.lat = 33; e.bsy = 33; e.t0 = cyc;
    if (o == 3'd0) begin
      p = {32'b0, x} * {32'b0, y};
      {mhi, mlo} = p;
`ifdef ALU_MULDIV_DIV_EN
    end else if ((o == 3'd2 || o == 3'd3) && y == 0) begin
      mlo = '1; mhi = x; e.div0 = 1'b1; e.lat = 2; e.bsy = 2;
    end else if (o == 3'd2) begin
      mlo = x / y; mhi = x % y;
    end else if (o == 3'd3) begin
      p = 64'(sa / sy); mlo = p[31:0];
      p = 64'(sa % sy); mhi = p[31:0];
`endif
    end else if (o == 3'd1) begin
      p = 64'(sa * sy);
      {mhi, mlo} = p;
    end else begin
      e.lat = 1; e.bsy = 0;
      if (o == 3'd4) mhi = x;
      else if (o == 3'd5) mlo = x;
      else e.err = 1'b1;
    end
    e.hi = mhi; e.lo = mlo;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      if (++n > 200) begin
        checks++;
        failures++;
        $display("FAIL idle_timeout got=%0d pending want=0", sb.size());
        sb.delete();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [2:0] o;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0); chk("rst_done", 64'(done), 0);
    chk("rst_hi", 64'(hi), 0); chk("rst_lo", 64'(lo), 0);
    chk("rst_div0", 64'(div0), 0); chk("rst_err", 64'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    issue(3'd0, 32'h34, 32'h12);
    wait_idle();
    issue(3'd1, 32'hFFFFFFFF, 32'h3);
    issue(3'd0, 32'hFFFFFFFF, 32'h3);
    issue(3'd3, 32'hFFFFFFF9, 32'h2);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    issue(3'd2, 32'h34, 32'h0);
    issue(3'd4, 32'hAAAA0000, 32'h0);
    issue(3'd5, 32'h0000AAAA, 32'h0);
    issue(3'd6, 32'h12345678, 32'h9);
    issue(3'd7, 32'h1, 32'h1);
    wait_idle();
    issue(3'd0, 32'hDEADBEEF, 32'h1234567);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h5555AAAA;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      if ($urandom_range(0, 3) == 0) wait_idle();
      issue(o, x, y);
    end
    wait_idle();
    start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(busy), 0); chk("midrst_done", 64'(done), 0);
    chk("midrst_hi", 64'(hi), 0); chk("midrst_lo", 64'(lo), 0);
    chk("midrst_div0", 64'(div0), 0); chk("midrst_err", 64'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    mhi = '0; mlo = '0;
    repeat (40) @(negedge clk);
    issue(3'd1, 32'h7, 32'hFFFFFFFE);
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit with HI/LO registers, parametrised in datapath width, serving as the multi-cycle companion to the single-cycle ALU in the CPU execute stage. It implements MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO with a start/busy/done handshake. HI/LO are read combinationally for MFHI/MFLO. The control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4 and even.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous, active-low; the only clock is `clk`.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 3: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved.
- `a` in WIDTH: multiplicand/dividend, or MTHI/MTLO source.
- `b` in WIDTH: multiplier/divisor.
- `busy` out 1: operation in progress; `start` is ignored while high.
- `done` out 1: one-cycle completion pulse.
- `hi` out WIDTH: HI register (product upper half / remainder).
- `lo` out WIDTH: LO register (product lower half / quotient).
- `div0` out 1: last divide had `b`=0; valid with `done`, held until next accepted start.
- `err` out 1: last op was reserved or disabled; same timing as `div0`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE/DONE + start:**
  - Multiply/divide ops latch operand magnitudes (signed ops take absolute values and record the result signs), clear the counter, clear `div0`/`err`, and go to CALC.
  - MTHI/MTLO write `hi`/`lo` from `a` at that edge, then go to DONE.
  - Reserved ops set `err` and go to DONE; HI/LO are unchanged.
- **CALC:** one radix-2 step per cycle for WIDTH cycles, then FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
- **FIX:** apply sign correction, write `hi`/`lo`, go to DONE.
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: quotient takes sign(a)^sign(b); remainder takes sign(a).
- **DONE:** `done`=1 for exactly one cycle. Next state is IDLE, or the new operation if `start` is high.
- Arithmetic:
  - Product is the full 2·WIDTH result; no overflow flag.
  - Unsigned magnitude of the most-negative value is 2^(WIDTH-1).
- Divide-by-zero: skip CALC and go to FIX. Result is `lo`=all ones and `hi`=`a` (raw, no sign fix); `div0`=1.
- DIV of most-negative value by −1: `lo`=most-negative value, `hi`=0; no flag.
- `start` with a reserved `op` while `busy`: ignored like any other start.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `div0`=0, `err`=0, state IDLE, counter 0.
- Mul/div accepted at edge E0:
  - `busy`=1 from E0 through the cycle before E(WIDTH+1).
  - `hi`/`lo` update and `done`=1 at E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - `busy`=0 in the `done` cycle.
- Divide-by-zero: `done` at E2.
- MTHI/MTLO/reserved: register written at E0; `done` at E1; `busy` never asserted.
- `hi`/`lo` are stable except at the documented write edge. Intermediate values are never visible.
- Back-to-back: a start in the `done` cycle is accepted, giving zero idle cycles.
- `rst_n`=0 mid-operation: at the next edge, return to reset values, discard the operation, and emit no `done`.

## Configuration
- `ALU_MULDIV_DIV_EN`:
  - **Defined:** divider datapath present; DIV/DIVU behave as specified.
  - **Undefined:** divider logic is not compiled. DIVU/DIV are treated as reserved: `err`=1, `done` at E1, HI/LO unchanged, `div0` stays 0.

## Structure
- Package `muldiv_pkg` holds:
  - op encoding localparams (OP_MULTU … OP_MTLO);
  - state enum (S_IDLE, S_CALC, S_FIX, S_DONE);
  - function `abs_mag` (signed → unsigned magnitude).
- One sub-module, `muldiv_step`: combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator.
  - Divide path wrapped in `ALU_MULDIV_DIV_EN`.
- Top module holds the FSM, counter, sign flags and the HI/LO registers.

## Test plan
WIDTH=32 for all scenarios.
- MULTU a=0x00000034, b=0x00000012 → `done` 33 cycles after start; `hi`=0x00000000, `lo`=0x000003A8; `busy` high for 33 cycles.
- MULT a=0xFFFFFFFF, b=0x00000003 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFD. Then MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFD.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU a=0x34, b=0 → `done` at E2, `div0`=1, `lo`=0xFFFFFFFF, `hi`=0x00000034. Without `ALU_MULDIV_DIV_EN` → `err`=1, HI/LO unchanged.
- MTHI 0xAAAA0000, then MTLO 0x0000AAAA → each gives `done` 1 cycle later with the value written and `busy` never high. `op`=110 → `err`=1.
- Handshake and reset:
  - Start MULTU with a different `op` pulsed mid-CALC → the second start is ignored and the result is unchanged.
  - Start in the `done` cycle → accepted.
  - `rst_n` low at cycle 10 of a MULT → all outputs 0 and no `done`.
